// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - N-phase traffic signal controller with green extension and empty-phase skip
// Advanced by rising edges of the ts strobe; every state lasts its duration in ticks.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES   = 4,
  parameter int GREEN_TICKS  = 3,
  parameter int YELLOW_TICKS = 1,
  parameter int RED_TICKS    = 1,
  parameter int MAX_EXT      = 2,
  parameter int SKIP_EMPTY   = 1,
  parameter int CNT_W        = 8
) (
  input  logic                          clkin,
  input  logic                          reset,
  input  logic                          ts,
  input  logic [NUM_PHASES-1:0]         sensor,
  output logic [1:0]                    state_out,
  output logic [$clog2(NUM_PHASES)-1:0] phase_out,
  output logic                          phase_chg
);

  localparam int PW = $clog2(NUM_PHASES);

  // Terminal counter values; a zero duration behaves as one tick.
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'((GREEN_TICKS  == 0) ? 0 : GREEN_TICKS  - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'((YELLOW_TICKS == 0) ? 0 : YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'((RED_TICKS    == 0) ? 0 : RED_TICKS    - 1);
  localparam logic [CNT_W-1:0] EXT_MAX = CNT_W'(MAX_EXT);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   phase_q;
  logic [PW-1:0]   phase_d;
  logic            chg_q;
  logic            ts_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ext_q;
  logic            tick;

  assign tick = ts & ~ts_q;

  // Next phase: first demanding index after the current one, current last; plain successor otherwise.
  always_comb begin
    int   inc;
    int   idx;
    logic found;
    inc = int'(phase_q) + 1;
    if (inc >= NUM_PHASES) inc = 0;
    phase_d = inc[PW-1:0];
    found   = 1'b0;
    idx     = 0;
    if (SKIP_EMPTY != 0) begin
      for (int i = 1; i <= NUM_PHASES; i++) begin
        idx = int'(phase_q) + i;
        if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
        if (!found && sensor[idx[PW-1:0]]) begin
          found   = 1'b1;
          phase_d = idx[PW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q <= S_RED;
      phase_q <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
      ext_q   <= '0;
      ts_q    <= 1'b1;
    end else begin
      ts_q  <= ts;
      chg_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_GREEN: begin
            if (cnt_q == G_LAST) begin
              if (sensor[phase_q] && (ext_q < EXT_MAX)) begin
                ext_q <= ext_q + CNT_W'(1);
                cnt_q <= G_LAST;
              end else begin
                state_q <= S_YELLOW;
                cnt_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_YELLOW: begin
            if (cnt_q == Y_LAST) begin
              state_q <= S_RED;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_RED: begin
            if (cnt_q == R_LAST) begin
              state_q <= S_GREEN;
              cnt_q   <= '0;
              ext_q   <= '0;
              phase_q <= phase_d;
              chg_q   <= (phase_d != phase_q);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= S_RED;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign state_out = state_q;
  assign phase_out = phase_q;
  assign phase_chg = chg_q;

endmodule
